branch_target_predictor: RTL and testbench

- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the 16-bit pipelined CPU.
- Lookup is indexed by the fetch-stage PC and supplies a predicted next PC in the same cycle, so the pipeline no longer flushes on every taken branch.
- The MEM stage, where branches resolve, reports the actual outcome through the update port. The block trains its table and flags mispredictions.
- A sequenced clear engine invalidates the table. Branch and mispredict statistics are kept for the VGA debug display.

---
 rtl/bp_pkg.sv | 18 +
 rtl/sat_counter.sv | 19 +
 rtl/branch_target_predictor.sv | 146 ++++++++++++++
 tb/tb_branch_target_predictor.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and helpers for the branch target predictor
package bp_pkg;

    typedef enum logic {ST_IDLE, ST_CLEAR} bp_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Counter value with only the MSB set: the weakest "taken" state.
    function automatic int weak_taken(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down step for a direction counter
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             inc,
    input  logic             dec,
    output logic [CTR_W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc && !dec && cur != {CTR_W{1'b1}})
            nxt = cur + CTR_W'(1);
        else if (dec && !inc && cur != '0)
            nxt = cur - CTR_W'(1);
    end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with direction counters, clear engine and stats
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic              upd_is_branch,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              clr,
    output logic              busy,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(weak_taken(CTR_W));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q [ENTRIES];

    bp_state_t          state_q, state_d;
    logic               clr_start;
    logic [IDX_W-1:0]   ptr_q;
    logic [STAT_W-1:0]  br_q, mp_q;

    logic [IDX_W-1:0]   lk_idx, upd_idx;
    logic [TAG_W-1:0]   lk_tag, upd_tag;
    logic               upd_fire, upd_hit;
    logic [CTR_W-1:0]   ctr_nxt;

    assign busy = (state_q == ST_CLEAR);

    // Lookup reads the registered table only; same-cycle updates are not bypassed.
    assign lk_idx      = lk_pc[IDX_W-1:0];
    assign lk_tag      = lk_pc[ADDR_W-1:IDX_W];
    assign pred_hit    = !busy && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_target = pred_taken ? tgt_q[lk_idx] : lk_pc + ADDR_W'(1);

    assign upd_idx  = upd_pc[IDX_W-1:0];
    assign upd_tag  = upd_pc[ADDR_W-1:IDX_W];
    assign upd_fire = upd_en && upd_is_branch && !busy;
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign mispredict  = upd_en && upd_is_branch &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(1);

    sat_counter #(.CTR_W(CTR_W)) u_ctr (
        .cur (ctr_q[upd_idx]),
        .inc (upd_taken),
        .dec (!upd_taken),
        .nxt (ctr_nxt)
    );

    always_comb begin
        state_d   = state_q;
        clr_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_start = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == IDX_W'(ENTRIES - 1))
                    state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= '0;
            end
        end else if (busy) begin
            valid_q[ptr_q] <= 1'b0;
            ctr_q[ptr_q]   <= '0;
        end else if (upd_fire) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_nxt;
                if (upd_taken)
                    tgt_q[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= upd_target;
                ctr_q[upd_idx]   <= CTR_WEAK;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            br_q    <= '0;
            mp_q    <= '0;
        end else begin
            state_q <= state_d;
            if (clr_start)
                ptr_q <= '0;
            else if (busy)
                ptr_q <= ptr_q + IDX_W'(1);
            // Starting a clear also restarts the statistics window.
            if (clr_start) begin
                br_q <= '0;
                mp_q <= '0;
            end else begin
                if (upd_fire && br_q != '1)
                    br_q <= br_q + STAT_W'(1);
                if (mispredict && !busy && mp_q != '1)
                    mp_q <= mp_q + STAT_W'(1);
            end
        end
    end

    assign stat_branches    = br_q;
    assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - randomized self-checking bench with behavioural BTB model
module tb_branch_target_predictor;

    localparam int N = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] lk_pc, upd_pc, upd_target, upd_pred_target;
    logic        upd_en, upd_is_branch, upd_taken, upd_pred_taken, clr;
    logic        pred_hit, pred_taken, mispredict, busy;
    logic [15:0] pred_target, redirect_pc, stat_branches, stat_mispredicts;
    logic        s_hit, s_taken, s_mp, s_busy;
    logic [15:0] s_tgt, s_redir;
    logic [3:0]  s_br, s_mpc;

    int total = 0;
    int bad   = 0;

    bit m_valid[N];
    int m_tag[N], m_tgt[N], m_ctr[N];
    int m_clr_left, m_br, m_mp, m_br4, m_mp4;

    always #5 CLK = ~CLK;

    branch_target_predictor dut (
        .CLK(CLK), .RST(RST), .lk_pc(lk_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_en(upd_en), .upd_is_branch(upd_is_branch),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .clr(clr), .busy(busy),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_target_predictor #(.STAT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .lk_pc(lk_pc), .pred_hit(s_hit), .pred_taken(s_taken),
        .pred_target(s_tgt), .upd_en(upd_en), .upd_is_branch(upd_is_branch),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(s_mp), .redirect_pc(s_redir), .clr(clr), .busy(s_busy),
        .stat_branches(s_br), .stat_mispredicts(s_mpc)
    );

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_clr_left = 0; m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
    endtask

    task automatic model_lookup(input int pc, output bit hit, output bit tk, output int tgt);
        int idx = pc % N;
        hit = (m_clr_left == 0) && m_valid[idx] && (m_tag[idx] == pc / N);
        tk  = hit && (m_ctr[idx] >= 2);
        tgt = tk ? m_tgt[idx] : (pc + 1) % 65536;
    endtask

    function automatic bit model_mispredict();
        if (!(upd_en && upd_is_branch)) return 0;
        return (upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target);
    endfunction

    function automatic int model_redirect();
        return upd_taken ? int'(upd_target) : (int'(upd_pc) + 1) % 65536;
    endfunction

    task automatic model_commit();
        bit busy_now = (m_clr_left > 0);
        bit fire     = upd_en && upd_is_branch && !busy_now;
        bit mp       = model_mispredict();
        int idx      = int'(upd_pc) % N;
        int tag      = int'(upd_pc) / N;
        if (fire) begin
            if (m_valid[idx] && m_tag[idx] == tag) begin
                if (upd_taken) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = int'(upd_target);
                end else begin
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
            end else if (upd_taken) begin
                m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = int'(upd_target); m_ctr[idx] = 2;
            end
            if (m_br < 65535) m_br++;
            if (m_br4 < 15) m_br4++;
        end
        if (mp && !busy_now) begin
            if (m_mp < 65535) m_mp++;
            if (m_mp4 < 15) m_mp4++;
        end
        if (busy_now) begin
            m_valid[N - m_clr_left] = 0;
            m_ctr[N - m_clr_left]   = 0;
            m_clr_left--;
        end else if (clr) begin
            m_clr_left = N; m_br = 0; m_mp = 0; m_br4 = 0; m_mp4 = 0;
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        upd_en = 0; upd_is_branch = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_pred_taken = 0; upd_pred_target = 0; clr = 0;
    endtask

    task automatic set_upd(input logic [15:0] pc, input logic t, input logic [15:0] tgt,
                           input logic pt, input logic [15:0] ptgt);
        upd_en = 1; upd_is_branch = 1; upd_pc = pc; upd_taken = t; upd_target = tgt;
        upd_pred_taken = pt; upd_pred_target = ptgt;
    endtask

    task automatic test_reset();
        RST = 0; idle_inputs(); lk_pc = 16'h0010; model_reset();
        #1;
        total += 5;
        if (pred_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b want 0", pred_hit); end
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
        if (pred_target !== 16'h0011) begin bad++; $display("FAIL reset_target: got %h want 0011", pred_target); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (stat_branches !== 16'h0 || stat_mispredicts !== 16'h0) begin
            bad++; $display("FAIL reset_stats: got %h/%h want 0/0", stat_branches, stat_mispredicts);
        end
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1;
    endtask

    task automatic test_first_update();
        lk_pc = 16'h0013;
        set_upd(16'h0013, 1, 16'h0040, 0, 16'h0014);
        #1;
        total += 3;
        if (mispredict !== 1'b1) begin bad++; $display("FAIL first_mispredict: got %b want 1", mispredict); end
        if (redirect_pc !== 16'h0040) begin bad++; $display("FAIL first_redirect: got %h want 0040", redirect_pc); end
        if (pred_hit !== 1'b0) begin bad++; $display("FAIL first_no_bypass: got %b want 0", pred_hit); end
        tick(); idle_inputs(); #1;
        total += 4;
        if (pred_hit !== 1'b1 || pred_taken !== 1'b1) begin
            bad++; $display("FAIL first_lookup: got hit=%b taken=%b want 1/1", pred_hit, pred_taken);
        end
        if (pred_target !== 16'h0040) begin bad++; $display("FAIL first_target: got %h want 0040", pred_target); end
        if (stat_branches !== 16'd1) begin bad++; $display("FAIL first_branches: got %0d want 1", stat_branches); end
        if (stat_mispredicts !== 16'd1) begin bad++; $display("FAIL first_mispredicts: got %0d want 1", stat_mispredicts); end
    endtask

    task automatic test_counter();
        logic        exp_tk;
        logic [15:0] exp_tgt;
        lk_pc = 16'h0013;
        for (int i = 0; i < 3; i++) begin
            set_upd(16'h0013, 1, 16'h0040, 1, 16'h0040);
            #1;
            total++;
            if (mispredict !== 1'b0) begin bad++; $display("FAIL ctr_up_mispredict: got %b want 0", mispredict); end
            tick();
        end
        for (int k = 1; k <= 3; k++) begin
            set_upd(16'h0013, 0, 16'h0040, 1, 16'h0040);
            tick(); idle_inputs(); #1;
            exp_tk  = (k == 1);
            exp_tgt = exp_tk ? 16'h0040 : 16'h0014;
            total += 2;
            if (pred_hit !== 1'b1) begin bad++; $display("FAIL ctr_dn%0d_hit: got %b want 1", k, pred_hit); end
            if (pred_taken !== exp_tk || pred_target !== exp_tgt) begin
                bad++; $display("FAIL ctr_dn%0d_pred: got %b/%h want %b/%h", k, pred_taken, pred_target, exp_tk, exp_tgt);
            end
        end
        set_upd(16'h0013, 1, 16'h0040, 0, 16'h0014);
        tick(); idle_inputs(); #1;
        total++;
        if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_floor: got %b want 0", pred_taken); end
        set_upd(16'h0013, 1, 16'h0050, 0, 16'h0014);
        tick(); idle_inputs(); #1;
        total += 2;
        if (pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_retrain: got %b want 1", pred_taken); end
        if (pred_target !== 16'h0050) begin bad++; $display("FAIL ctr_newtarget: got %h want 0050", pred_target); end
        total += 2;
        if (stat_branches !== 16'(m_br)) begin bad++; $display("FAIL ctr_branches: got %0d want %0d", stat_branches, m_br); end
        if (stat_mispredicts !== 16'(m_mp)) begin bad++; $display("FAIL ctr_mispredicts: got %0d want %0d", stat_mispredicts, m_mp); end
    endtask

    task automatic test_alias();
        lk_pc = 16'h0023; #1;
        total++;
        if (pred_hit !== 1'b0) begin bad++; $display("FAIL alias_miss: got %b want 0", pred_hit); end
        set_upd(16'h0023, 1, 16'h0100, 0, 16'h0024);
        tick(); idle_inputs();
        lk_pc = 16'h0013; #1;
        total++;
        if (pred_hit !== 1'b0) begin bad++; $display("FAIL alias_evicted: got %b want 0", pred_hit); end
        lk_pc = 16'h0023; #1;
        total++;
        if (pred_hit !== 1'b1 || pred_target !== 16'h0100) begin
            bad++; $display("FAIL alias_new: got %b/%h want 1/0100", pred_hit, pred_target);
        end
    endtask

    task automatic test_wrap();
        lk_pc = 16'hFFFF; upd_en = 0; upd_pc = 16'hFFFF; upd_taken = 0; #1;
        total += 3;
        if (pred_hit !== 1'b0 || pred_target !== 16'h0000) begin
            bad++; $display("FAIL wrap_lookup: got %b/%h want 0/0000", pred_hit, pred_target);
        end
        if (redirect_pc !== 16'h0000) begin bad++; $display("FAIL wrap_redirect: got %h want 0000", redirect_pc); end
        if (mispredict !== 1'b0) begin bad++; $display("FAIL wrap_noupd: got %b want 0", mispredict); end
        idle_inputs();
    endtask

    task automatic test_random();
        bit h, tk; int tg;
        for (int c = 0; c < 400; c++) begin
            lk_pc = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom_range(0, 47));
            upd_en        = ($urandom % 4 != 0);
            upd_is_branch = ($urandom % 4 != 0);
            upd_pc        = 16'($urandom_range(0, 47));
            upd_taken     = 1'($urandom);
            upd_target    = ($urandom % 2 == 0) ? 16'($urandom_range(0, 7) * 16) : 16'($urandom);
            if ($urandom % 2 == 0) begin
                model_lookup(int'(upd_pc), h, tk, tg);
                upd_pred_taken = tk; upd_pred_target = 16'(tg);
            end else begin
                upd_pred_taken = 1'($urandom); upd_pred_target = 16'($urandom);
            end
            clr = ($urandom % 97 == 0);
            #1;
            model_lookup(int'(lk_pc), h, tk, tg);
            total += 8;
            if (pred_hit !== h || s_hit !== h) begin bad++; $display("FAIL rnd%0d_hit: got %b/%b want %b", c, pred_hit, s_hit, h); end
            if (pred_taken !== tk || s_taken !== tk) begin bad++; $display("FAIL rnd%0d_taken: got %b/%b want %b", c, pred_taken, s_taken, tk); end
            if (pred_target !== 16'(tg) || s_tgt !== 16'(tg)) begin bad++; $display("FAIL rnd%0d_target: got %h/%h want %h", c, pred_target, s_tgt, 16'(tg)); end
            if (mispredict !== model_mispredict() || s_mp !== model_mispredict()) begin
                bad++; $display("FAIL rnd%0d_mispredict: got %b/%b want %b", c, mispredict, s_mp, model_mispredict());
            end
            if (redirect_pc !== 16'(model_redirect()) || s_redir !== 16'(model_redirect())) begin
                bad++; $display("FAIL rnd%0d_redirect: got %h want %h", c, redirect_pc, 16'(model_redirect()));
            end
            if (busy !== (m_clr_left > 0) || s_busy !== (m_clr_left > 0)) begin
                bad++; $display("FAIL rnd%0d_busy: got %b/%b want %b", c, busy, s_busy, m_clr_left > 0);
            end
            if (stat_branches !== 16'(m_br) || stat_mispredicts !== 16'(m_mp)) begin
                bad++; $display("FAIL rnd%0d_stats: got %0d/%0d want %0d/%0d", c, stat_branches, stat_mispredicts, m_br, m_mp);
            end
            if (s_br !== 4'(m_br4) || s_mpc !== 4'(m_mp4)) begin
                bad++; $display("FAIL rnd%0d_stats4: got %0d/%0d want %0d/%0d", c, s_br, s_mpc, m_br4, m_mp4);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < N + 1 && m_clr_left > 0; i++) tick();
    endtask

    task automatic test_clear();
        int busy_cycles = 0;
        logic [15:0] pcs [5];
        pcs[0] = 16'h0031; pcs[1] = 16'h0005; pcs[2] = 16'h000C; pcs[3] = 16'h0023; pcs[4] = 16'h0047;
        for (int i = 0; i < 5; i++) begin
            set_upd(pcs[i], 1, 16'h0200 + 16'(i), 0, 16'h0000);
            tick();
        end
        idle_inputs();
        lk_pc = 16'h0005; clr = 1; #1;
        total++;
        if (busy !== 1'b0 || pred_hit !== 1'b1) begin
            bad++; $display("FAIL clr_pre: got busy=%b hit=%b want 0/1", busy, pred_hit);
        end
        tick(); clr = 0;
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            if (c == 3) set_upd(16'h0031, 1, 16'h0077, 0, 16'h0032);
            if (c == 6) clr = 1;
            #1;
            if (busy === 1'b1) busy_cycles++;
            total += 3;
            if (busy !== (m_clr_left > 0)) begin bad++; $display("FAIL clr%0d_busy: got %b want %b", c, busy, m_clr_left > 0); end
            if (m_clr_left > 0 && (pred_hit !== 1'b0 || pred_taken !== 1'b0)) begin
                bad++; $display("FAIL clr%0d_forced: got %b/%b want 0/0", c, pred_hit, pred_taken);
            end
            if (mispredict !== model_mispredict()) begin
                bad++; $display("FAIL clr%0d_mispredict: got %b want %b", c, mispredict, model_mispredict());
            end
            tick();
        end
        idle_inputs();
        total++;
        if (busy_cycles != N) begin bad++; $display("FAIL clr_length: got %0d want %0d", busy_cycles, N); end
        for (int i = 0; i < 5; i++) begin
            lk_pc = pcs[i]; #1;
            total++;
            if (pred_hit !== 1'b0) begin bad++; $display("FAIL clr_empty_%h: got %b want 0", pcs[i], pred_hit); end
        end
        total++;
        if (stat_branches !== 16'h0 || stat_mispredicts !== 16'h0) begin
            bad++; $display("FAIL clr_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_reset_mid_clear();
        set_upd(16'h000C, 1, 16'h0300, 0, 16'h0000); tick();
        set_upd(16'h0002, 1, 16'h0301, 0, 16'h0000); tick();
        idle_inputs();
        clr = 1; tick(); clr = 0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstclr_busy_before: got %b want 1", busy); end
        RST = 0; #1;
        model_reset();
        lk_pc = 16'h000C; #1;
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstclr_busy: got %b want 0", busy); end
        if (pred_hit !== 1'b0) begin bad++; $display("FAIL rstclr_hit0c: got %b want 0", pred_hit); end
        @(posedge CLK); #1;
        RST = 1;
        lk_pc = 16'h0002; #1;
        total++;
        if (pred_hit !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstclr_after: got hit=%b busy=%b want 0/0", pred_hit, busy);
        end
    endtask

    task automatic test_stat_saturation();
        for (int i = 0; i < 20; i++) begin
            set_upd(16'h0009, 0, 16'h0000, 1, 16'h0055);
            tick();
            total++;
            if (s_br !== 4'(m_br4) || s_mpc !== 4'(m_mp4)) begin
                bad++; $display("FAIL sat%0d: got %0d/%0d want %0d/%0d", i, s_br, s_mpc, m_br4, m_mp4);
            end
        end
        idle_inputs(); #1;
        total += 2;
        if (s_br !== 4'hF || s_mpc !== 4'hF) begin bad++; $display("FAIL sat_final: got %h/%h want F/F", s_br, s_mpc); end
        if (stat_branches !== 16'd20 || stat_mispredicts !== 16'd20) begin
            bad++; $display("FAIL sat_wide: got %0d/%0d want 20/20", stat_branches, stat_mispredicts);
        end
    endtask

    initial begin
        test_reset();
        test_first_update();
        test_counter();
        test_alias();
        test_wrap();
        test_random();
        test_clear();
        test_reset_mid_clear();
        test_stat_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
